// File: rtl/testdrive_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// testdrive_axi4_lite_reg_slave
//
// AXI4-Lite slave holding a bank of C_REG_COUNT 32-bit registers. The AW and W
// channels are accepted independently and in either order. Byte-masked writes
// are committed one cycle after both have been captured. Reads are answered
// one cycle after the AR handshake. Word indices at or above C_REG_COUNT
// decode as an error and return SLVERR.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-high reset
//   AW*/W*/B*                 AXI4-Lite write address / data / response
//   AR*/R*                    AXI4-Lite read address / data
//   UWE, UWIDX, UWDATA        user-side pulse for each committed in-range write
//                             (index and post-merge word)
//   URIDX, URDATA             user read-back port, one cycle latency, 0 when
//                             the index is out of range
// ---------------------------------------------------------------------------
module testdrive_axi4_lite_reg_slave #(
  parameter int          C_ADDR_BITS  = 10,
  parameter int          C_REG_COUNT  = 16,
  parameter logic [31:0] C_INIT_VALUE = 32'h0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [C_ADDR_BITS-1:0] AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [C_ADDR_BITS-1:0] ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic                   UWE,
  output logic [C_ADDR_BITS-3:0] UWIDX,
  output logic [31:0]            UWDATA,
  input  logic [C_ADDR_BITS-3:0] URIDX,
  output logic [31:0]            URDATA
);

  localparam int IW = C_ADDR_BITS - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_e;

  // Register bank
  logic [31:0]   regs_q [C_REG_COUNT];

  // Write side state
  wstate_e       wstate_q;
  logic          aw_held_q;
  logic          w_held_q;
  logic [IW-1:0] awidx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          wr_err_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          uwe_q;
  logic [IW-1:0] uwidx_q;
  logic [31:0]   uwdata_q;

  // Read side state
  rstate_e       rstate_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [31:0]   rdata_q;
  logic [31:0]   urdata_q;

  // Next-value / combinational helpers
  logic          aw_hs_d;
  logic          w_hs_d;
  logic          aw_held_d;
  logic          w_held_d;
  logic [IW-1:0] awidx_d;
  logic [31:0]   wdata_d;
  logic [3:0]    wstrb_d;
  logic          wr_ok_d;
  logic [31:0]   wr_old_d;
  logic [31:0]   wr_merge_d;
  logic [IW-1:0] aridx_d;
  logic          rd_ok_d;
  logic [31:0]   ar_data_d;
  logic [31:0]   ur_data_d;

  // Byte-address LSBs are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  function automatic logic idx_in_range(input logic [IW-1:0] idx);
    return ({1'b0, idx} < (IW+1)'(C_REG_COUNT));
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Capture muxing: a handshake this cycle supplies the value, otherwise the
  // previously captured one is kept. The merge is computed at the capture
  // edge so UWDATA is already valid while UWE is high; only the write FSM
  // modifies the bank, so the merged word is still current one edge later.
  always_comb begin
    aw_hs_d   = AWVALID && awready_q;
    w_hs_d    = WVALID && wready_q;
    aw_held_d = aw_held_q || aw_hs_d;
    w_held_d  = w_held_q || w_hs_d;
    awidx_d   = aw_hs_d ? AWADDR[C_ADDR_BITS-1:2] : awidx_q;
    wdata_d   = w_hs_d ? WDATA : wdata_q;
    wstrb_d   = w_hs_d ? WSTRB : wstrb_q;
    wr_ok_d   = idx_in_range(awidx_d);
    wr_old_d  = 32'h0;
    for (int i = 0; i < C_REG_COUNT; i++) begin
      if (awidx_d == IW'(i)) wr_old_d = regs_q[i];
    end
    wr_merge_d = merge_bytes(wr_old_d, wdata_d, wstrb_d);
  end

  always_comb begin
    aridx_d   = ARADDR[C_ADDR_BITS-1:2];
    rd_ok_d   = idx_in_range(aridx_d);
    ar_data_d = 32'h0;
    ur_data_d = 32'h0;
    for (int i = 0; i < C_REG_COUNT; i++) begin
      if (aridx_d == IW'(i)) ar_data_d = regs_q[i];
      if (URIDX == IW'(i))   ur_data_d = regs_q[i];
    end
  end

  // Write FSM and register bank
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_err_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      uwe_q     <= 1'b0;
      uwidx_q   <= '0;
      uwdata_q  <= '0;
      for (int i = 0; i < C_REG_COUNT; i++) regs_q[i] <= C_INIT_VALUE;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
          awidx_q   <= awidx_d;
          wdata_q   <= wdata_d;
          wstrb_q   <= wstrb_d;
          if (aw_held_d && w_held_d) begin
            wstate_q  <= W_COMMIT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            uwe_q     <= wr_ok_d;
            wr_err_q  <= !wr_ok_d;
            if (wr_ok_d) begin
              uwidx_q  <= awidx_d;
              uwdata_q <= wr_merge_d;
            end
          end else begin
            // READY reasserts on the first edge out of reset as well.
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        W_COMMIT: begin
          uwe_q    <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q  <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
          if (!wr_err_q) begin
            for (int i = 0; i < C_REG_COUNT; i++) begin
              if (uwidx_q == IW'(i)) regs_q[i] <= uwdata_q;
            end
          end
          wstate_q <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM and user read-back. Both sample the bank before any commit on
  // the same edge, so a colliding read returns the old word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      urdata_q  <= '0;
    end else begin
      urdata_q <= ur_data_d;
      case (rstate_q)
        R_IDLE: begin
          if (ARVALID && arready_q) begin
            rdata_q   <= ar_data_d;
            rresp_q   <= rd_ok_d ? RESP_OKAY : RESP_SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign UWE     = uwe_q;
  assign UWIDX   = uwidx_q;
  assign UWDATA  = uwdata_q;
  assign URDATA  = urdata_q;

endmodule

// File: tb/tb_testdrive_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// Bench for testdrive_axi4_lite_reg_slave: a table of directed transactions,
// hand-written multi-cycle sequences (delayed AW, read/commit collision,
// mid-transaction reset) and randomized traffic checked against a word-array
// model of the register bank.
// ---------------------------------------------------------------------------
module tb_testdrive_axi4_lite_reg_slave;

  localparam int NREG = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [9:0]  ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        UWE;
  logic [7:0]  UWIDX;
  logic [31:0] UWDATA;
  logic [7:0]  URIDX = '0;
  logic [31:0] URDATA;

  testdrive_axi4_lite_reg_slave #(
    .C_ADDR_BITS (10),
    .C_REG_COUNT (NREG),
    .C_INIT_VALUE(32'h0)
  ) dut (
    .CLK(CLK), .RST(RST),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .UWE(UWE), .UWIDX(UWIDX), .UWDATA(UWDATA),
    .URIDX(URIDX), .URDATA(URDATA)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [NREG];

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int word_idx(input logic [9:0] addr);
    return int'(addr >> 2);
  endfunction

  function automatic logic [31:0] ref_read(input logic [9:0] addr);
    int i;
    i = word_idx(addr);
    return (i < NREG) ? model[i] : 32'h0;
  endfunction

  function automatic logic [1:0] ref_resp(input logic [9:0] addr);
    return (word_idx(addr) < NREG) ? 2'b00 : 2'b10;
  endfunction

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int br_dly,
                          input logic [1:0] exp_resp);
    bit          aw_done, w_done, hs_aw, hs_w, ok;
    int          t, idx;
    logic [31:0] merged;
    idx     = word_idx(addr);
    ok      = (idx < NREG);
    merged  = ok ? ref_merge(model[idx], data, strb) : 32'h0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    t       = 0;
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    while (!(aw_done && w_done)) begin
      AWVALID = !aw_done && (t >= aw_dly);
      WVALID  = !w_done && (t >= w_dly);
      chk("awready_wait", 32'(AWREADY), 32'(!aw_done));
      chk("wready_wait", 32'(WREADY), 32'(!w_done));
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      @(posedge CLK); #1;
      t++;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      if (t > 40) begin
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("write_handshake_timeout", 32'(t), 32'd0);
        return;
      end
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    // cycle after the last handshake edge: commit cycle
    chk("uwe_pulse", 32'(UWE), 32'(ok));
    if (ok) begin
      chk("uwidx", 32'(UWIDX), 32'(idx));
      chk("uwdata", UWDATA, merged);
    end
    chk("readys_drop", 32'({AWREADY, WREADY}), 32'd0);
    chk("bvalid_early", 32'(BVALID), 32'd0);
    @(posedge CLK); #1;
    chk("uwe_end", 32'(UWE), 32'd0);
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'(exp_resp));
    for (int i = 0; i < br_dly; i++) begin
      @(posedge CLK); #1;
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("bresp_hold", 32'(BRESP), 32'(exp_resp));
      chk("readys_hold", 32'({AWREADY, WREADY, UWE}), 32'd0);
    end
    BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    chk("bvalid_clear", 32'(BVALID), 32'd0);
    chk("readys_back", 32'({AWREADY, WREADY}), 32'd3);
    if (ok) model[idx] = merged;
  endtask

  task automatic do_read(input logic [9:0] addr, input int rr_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    n       = 0;
    ARADDR  = addr;
    ARVALID = 1'b1;
    while (!ARREADY) begin
      @(posedge CLK); #1;
      n++;
      if (n > 20) begin
        ARVALID = 1'b0;
        chk("arready_timeout", 32'(n), 32'd0);
        return;
      end
    end
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    chk("rvalid", 32'(RVALID), 32'd1);
    chk("arready_low", 32'(ARREADY), 32'd0);
    chk("rdata", RDATA, exp_data);
    chk("rresp", 32'(RRESP), 32'(exp_resp));
    for (int i = 0; i < rr_dly; i++) begin
      @(posedge CLK); #1;
      chk("rvalid_hold", 32'(RVALID), 32'd1);
      chk("rdata_hold", RDATA, exp_data);
      chk("arready_hold", 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    @(posedge CLK); #1;
    RREADY = 1'b0;
    chk("rvalid_clear", 32'(RVALID), 32'd0);
    chk("arready_back", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w;
    logic [9:0]  a;
    int          uri;

    for (int i = 0; i < NREG; i++) model[i] = 32'h0;

    tbl[0]  = '{1'b1, 10'h008, 32'hDEADBEEF, 4'hF,    0, 0, 0, 32'h0,        2'b00};
    tbl[1]  = '{1'b0, 10'h008, 32'h0,        4'h0,    0, 0, 0, 32'hDEADBEEF, 2'b00};
    tbl[2]  = '{1'b1, 10'h00C, 32'hAABBCCDD, 4'hF,    0, 2, 0, 32'h0,        2'b00};
    tbl[3]  = '{1'b1, 10'h040, 32'h12345678, 4'hF,    0, 0, 5, 32'h0,        2'b10};
    tbl[4]  = '{1'b0, 10'h040, 32'h0,        4'h0,    0, 0, 5, 32'h0,        2'b10};
    tbl[5]  = '{1'b0, 10'h00B, 32'h0,        4'h0,    0, 0, 0, 32'hDEADBEEF, 2'b00};
    tbl[6]  = '{1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 32'h0,        2'b00};
    tbl[7]  = '{1'b0, 10'h010, 32'h0,        4'h0,    0, 0, 0, 32'h0,        2'b00};
    tbl[8]  = '{1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF,    1, 0, 1, 32'h0,        2'b10};
    tbl[9]  = '{1'b0, 10'h3FC, 32'h0,        4'h0,    0, 0, 0, 32'h0,        2'b10};
    tbl[10] = '{1'b1, 10'h03C, 32'h0000A5A5, 4'b0011, 0, 0, 0, 32'h0,        2'b00};
    tbl[11] = '{1'b0, 10'h03C, 32'h0,        4'h0,    0, 0, 0, 32'h0000A5A5, 2'b00};

    // Reset state
    @(posedge CLK); #1;
    chk("reset_ctrl", 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, UWE}), 32'd0);
    chk("reset_rdata", RDATA, 32'h0);
    chk("reset_uwdata", UWDATA, 32'h0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    chk("ready_after_reset", 32'({AWREADY, WREADY, ARREADY}), 32'd7);

    // Directed table
    for (int v = 0; v < 12; v++) begin
      if (tbl[v].wr)
        do_write(tbl[v].addr, tbl[v].data, tbl[v].strb, tbl[v].aw_dly, tbl[v].w_dly,
                 tbl[v].rdy_dly, tbl[v].exp_resp);
      else
        do_read(tbl[v].addr, tbl[v].rdy_dly, tbl[v].exp_data, tbl[v].exp_resp);
    end

    // W arrives 3 cycles ahead of AW, partial strobe over 0xAABBCCDD
    do_write(10'h00C, 32'h11223344, 4'b0101, 3, 0, 0, 2'b00);
    do_read(10'h00C, 0, 32'hAA22CC44, 2'b00);

    // Whole bank via the user read-back port, plus one index past the end
    for (int i = 0; i <= NREG; i++) begin
      URIDX = 8'(i);
      @(posedge CLK); #1;
      chk("urdata_sweep", URDATA, (i < NREG) ? model[i] : 32'h0);
    end

    // AR handshake on the commit edge of a write to the same word
    URIDX   = 8'd1;
    old_w   = model[1];
    AWADDR  = 10'h004;
    WDATA   = 32'h00000055;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("coll_uwe", 32'(UWE), 32'd1);
    ARADDR  = 10'h004;
    ARVALID = 1'b1;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    chk("coll_bvalid", 32'(BVALID), 32'd1);
    chk("coll_rvalid", 32'(RVALID), 32'd1);
    chk("coll_rdata_old", RDATA, 32'h0);
    chk("coll_urdata_old", URDATA, old_w);
    BREADY = 1'b1;
    RREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    RREADY = 1'b0;
    model[1] = 32'h00000055;
    chk("coll_urdata_new", URDATA, 32'h00000055);
    do_read(10'h004, 0, 32'h00000055, 2'b00);

    // Reset while the write side sits in its response state and a read is pending
    AWADDR  = 10'h014;
    WDATA   = 32'h00000077;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    @(posedge CLK); #1;
    ARADDR  = 10'h008;
    ARVALID = 1'b1;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    chk("pre_rst_valids", 32'({BVALID, RVALID}), 32'd3);
    #3 RST = 1'b1;
    #1;
    chk("async_rst_ctrl", 32'({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, UWE}), 32'd0);
    chk("async_rst_rdata", RDATA, 32'h0);
    chk("async_rst_urdata", URDATA, 32'h0);
    @(posedge CLK); #1;
    chk("rst_hold_ready", 32'({AWREADY, WREADY, ARREADY}), 32'd0);
    #3 RST = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = 32'h0;
    @(posedge CLK); #1;
    chk("rst_release_ready", 32'({AWREADY, WREADY, ARREADY}), 32'd7);
    chk("rst_no_resp", 32'({BVALID, RVALID}), 32'd0);
    do_read(10'h008, 0, 32'h0, 2'b00);
    do_read(10'h014, 0, 32'h0, 2'b00);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      uri   = $urandom_range(0, 19);
      URIDX = 8'(uri);
      a     = (10'($urandom_range(0, 19)) << 2) | 10'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), ref_resp(a));
      else
        do_read(a, $urandom_range(0, 2), ref_read(a), ref_resp(a));
      chk("rand_urdata", URDATA, (uri < NREG) ? model[uri] : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
